ppwm_exec: RTL and testbench
============================

Name: ppwm_exec

Overview:
- Execution core of the programmable PWM. It fetches 8-bit instructions from the program memory, one per cycle, and decodes the command set (CTRL, SET, ARITH, SHIFT, JUMP, CMP, BRANCH).
- It maintains the PWM value, a scratch register and a compare flag.
- It sits between the program store (upstream, combinational read port) and the PWM output comparator (downstream, consumes pwm_val_o).

Parameters:
- DATA_W, 8: width of PWM value, register and global counter.
- ADDR_W, 4: program counter width; program depth is 2^ADDR_W.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  run enable.
- instr_addr_o  out  ADDR_W  program counter, registered.
- instr_i  in  8  instruction at instr_addr_o, valid in the same cycle (combinational memory read).
- gcnt_i  in  DATA_W  global free-running counter.
- pwm_val_o  out  DATA_W  PWM compare value.
- reg_o  out  DATA_W  scratch register.
- cond_o  out  1  compare flag.
- running_o  out  1  state==RUN.
- halted_o  out  1  state==HALT.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE.
  - instr_addr_o, pwm_val_o and reg_o = 0.
  - cond_o, running_o and halted_o = 0.
- Encoding:
  - instr[7:5]=cmd.
  - instr[4]=tgt (0 = PWM, 1 = REG).
  - instr[3:0]=fld.
  - off5={instr[4],fld}, a signed 5-bit offset in the range -16..+15.
- FSM:
  - IDLE: en_i=1 -> RUN. No instruction is executed in this cycle.
  - RUN: one instruction at instr_addr_o is executed per cycle.
    - en_i=0 -> IDLE. That cycle's instruction is not executed.
    - A HALT instruction -> HALT.
  - HALT: holds pc and all values; en_i=0 -> IDLE.
  - Entering IDLE from RUN or HALT: pc<=0. pwm_val_o, reg_o and cond_o are retained.
- Timing: all effects of the instruction executed in cycle N are visible at the outputs in cycle N+1. The default pc update is pc+1, modulo 2^ADDR_W (wraps 2^ADDR_W-1 -> 0).
- CTRL:
  - fld=0001: HALT; pc unchanged.
  - fld=0010: RESTART; pc<=0.
  - All other fld values: NOP.
- SET: target <= zero-extended fld.
- ARITH: target <= target + sign-extended fld (-8..+7), wrapping modulo 2^DATA_W. No saturation and no flags.
- SHIFT: logical shift of the target with zero fill.
  - fld[3]=0 shifts left, fld[3]=1 shifts right.
  - Amount = fld[2:0], 0..7; amount 0 leaves the target unchanged.
- RSRV: NOP; pc+1.
- JUMP: pc <= pc + sign-extended off5, modulo 2^ADDR_W. Offset 0 is a one-instruction spin loop.
- CMP: sets cond from fld[2:0]; tgt is ignored; all comparisons unsigned.
  - 000: gcnt<pwm.
  - 100: gcnt>=pwm.
  - 001: gcnt<reg.
  - 101: gcnt>=reg.
  - 010: pwm==reg.
  - Any other code: cond<=0.
- BRANCH:
  - cond=1: pc <= pc + sign-extended off5.
  - cond=0: pc+1.
  - cond is not modified.
- Only CMP writes cond. Only SET/ARITH/SHIFT write pwm or reg. gcnt_i is sampled in the same cycle as the CMP executes.
- Reset asserted mid-RUN: all state is cleared immediately (asynchronous). After release, the block waits in IDLE for en_i.
- en_i deasserted in the same cycle as a HALT instruction: the transition to IDLE takes priority and the HALT is not executed.

Test Plan:
- SET/ARITH wrap: program {SET pwm 0xF, ARITH pwm +7, ARITH pwm -8, HALT}.
  - After the 4th RUN cycle pwm_val_o=0x0E.
  - halted_o=1 and instr_addr_o=3.
  - Separately, from a PWM value of 0x02, ARITH -3 -> 0xFF.
- SHIFT: SET reg 0x9, SHIFT reg left 4 -> reg_o=0x90; SHIFT reg right 7 -> 0x01; SHIFT left 0 -> unchanged.
- Loop via JUMP/BRANCH: program {SET pwm 4, CMP 000, BRANCH -1, ARITH pwm +1, JUMP -3}. Hold gcnt_i=2.
  - cond_o=1 and the CMP/BRANCH pair loops on pc 1..2.
  - Raise gcnt_i to 5: the branch falls through and pwm increments to 5 on the next pass.
- PC wrap: 16 NOPs. pc counts 0..15 then 0. A JUMP -16 at pc 3 lands on pc 3 (spin).
- FSM: HALT, then en_i=0 -> IDLE with pc=0 and pwm/reg retained. en_i=1 -> execution restarts at pc 0 one cycle later.
- Reset mid-run: assert rst_ni low asynchronously between clock edges while pwm_val_o=0x55. All outputs are 0 immediately, state is IDLE, and no execution occurs until en_i=1.

Source files
------------

// File: rtl/ppwm_exec.sv
// Execution core of the programmable PWM: fetches one 8-bit instruction per cycle
// and updates the PWM value, scratch register, compare flag and program counter.
module ppwm_exec #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    output logic [ADDR_W-1:0] instr_addr_o,
    input  logic [7:0]        instr_i,
    input  logic [DATA_W-1:0] gcnt_i,
    output logic [DATA_W-1:0] pwm_val_o,
    output logic [DATA_W-1:0] reg_o,
    output logic              cond_o,
    output logic              running_o,
    output logic              halted_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CMD_CTRL   = 3'd0,
        CMD_SET    = 3'd1,
        CMD_ARITH  = 3'd2,
        CMD_SHIFT  = 3'd3,
        CMD_RSRV   = 3'd4,
        CMD_JUMP   = 3'd5,
        CMD_CMP    = 3'd6,
        CMD_BRANCH = 3'd7
    } cmd_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_pwm;
    logic [DATA_W-1:0]   r_reg;
    logic                r_cond;

    cmd_t                w_cmd;
    logic                w_tgt;
    logic [3:0]          w_fld;
    logic [4:0]          w_off5;
    logic [ADDR_W+4:0]   w_off_ext;
    logic [DATA_W+3:0]   w_fld_sx;
    logic [DATA_W+3:0]   w_fld_zx;
    logic [DATA_W-1:0]   w_tgt_val;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_pc_rel;

    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [DATA_W-1:0]   w_tgt_nxt;
    logic                w_tgt_wr;
    logic                w_cond_nxt;
    logic                w_cond_wr;
    logic                w_halt;

    assign w_cmd     = cmd_t'(instr_i[7:5]);
    assign w_tgt     = instr_i[4];
    assign w_fld     = instr_i[3:0];
    assign w_off5    = {instr_i[4], instr_i[3:0]};
    assign w_off_ext = {{ADDR_W{w_off5[4]}}, w_off5};
    assign w_fld_sx  = {{DATA_W{w_fld[3]}}, w_fld};
    assign w_fld_zx  = {{DATA_W{1'b0}}, w_fld};
    assign w_tgt_val = w_tgt ? r_reg : r_pwm;
    assign w_pc_inc  = r_pc + ADDR_W'(1);
    // Relative targets wrap modulo program depth, so a -16 offset on a 16-deep store spins.
    assign w_pc_rel  = r_pc + w_off_ext[ADDR_W-1:0];

    always_comb begin
        w_pc_nxt   = w_pc_inc;
        w_tgt_nxt  = w_tgt_val;
        w_tgt_wr   = 1'b0;
        w_cond_nxt = r_cond;
        w_cond_wr  = 1'b0;
        w_halt     = 1'b0;
        case (w_cmd)
            CMD_CTRL: begin
                if (w_fld == 4'b0001) begin
                    w_halt   = 1'b1;
                    w_pc_nxt = r_pc;
                end else if (w_fld == 4'b0010) begin
                    w_pc_nxt = '0;
                end
            end
            CMD_SET: begin
                w_tgt_nxt = w_fld_zx[DATA_W-1:0];
                w_tgt_wr  = 1'b1;
            end
            CMD_ARITH: begin
                w_tgt_nxt = w_tgt_val + w_fld_sx[DATA_W-1:0];
                w_tgt_wr  = 1'b1;
            end
            CMD_SHIFT: begin
                w_tgt_nxt = w_fld[3] ? (w_tgt_val >> w_fld[2:0]) : (w_tgt_val << w_fld[2:0]);
                w_tgt_wr  = 1'b1;
            end
            CMD_JUMP: begin
                w_pc_nxt = w_pc_rel;
            end
            CMD_CMP: begin
                w_cond_wr = 1'b1;
                case (w_fld[2:0])
                    3'b000:  w_cond_nxt = (gcnt_i <  r_pwm);
                    3'b100:  w_cond_nxt = (gcnt_i >= r_pwm);
                    3'b001:  w_cond_nxt = (gcnt_i <  r_reg);
                    3'b101:  w_cond_nxt = (gcnt_i >= r_reg);
                    3'b010:  w_cond_nxt = (r_pwm == r_reg);
                    default: w_cond_nxt = 1'b0;
                endcase
            end
            CMD_BRANCH: begin
                if (r_cond) begin
                    w_pc_nxt = w_pc_rel;
                end
            end
            default: begin
                w_pc_nxt = w_pc_inc;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_pwm   <= '0;
            r_reg   <= '0;
            r_cond  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en_i) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Dropping enable wins over anything the current instruction would do.
                    if (!en_i) begin
                        r_state <= ST_IDLE;
                        r_pc    <= '0;
                    end else begin
                        r_pc <= w_pc_nxt;
                        if (w_halt) begin
                            r_state <= ST_HALT;
                        end
                        if (w_tgt_wr) begin
                            if (w_tgt) begin
                                r_reg <= w_tgt_nxt;
                            end else begin
                                r_pwm <= w_tgt_nxt;
                            end
                        end
                        if (w_cond_wr) begin
                            r_cond <= w_cond_nxt;
                        end
                    end
                end
                ST_HALT: begin
                    if (!en_i) begin
                        r_state <= ST_IDLE;
                        r_pc    <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_pc    <= '0;
                end
            endcase
        end
    end

    assign instr_addr_o = r_pc;
    assign pwm_val_o    = r_pwm;
    assign reg_o        = r_reg;
    assign cond_o       = r_cond;
    assign running_o    = (r_state == ST_RUN);
    assign halted_o     = (r_state == ST_HALT);

endmodule

// File: tb/tb_ppwm_exec.sv
// Directed bench for ppwm_exec: small programs in a behavioural store, hand-computed expectations.
module tb_ppwm_exec;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] addr;
    logic [7:0] instr;
    logic [7:0] gcnt;
    logic [7:0] pwm;
    logic [7:0] rg;
    logic       cond;
    logic       running;
    logic       halted;

    logic [7:0] mem [16];
    int n_cmp = 0;
    int n_err = 0;

    assign instr = mem[addr];

    ppwm_exec #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .instr_addr_o (addr),
        .instr_i      (instr),
        .gcnt_i       (gcnt),
        .pwm_val_o    (pwm),
        .reg_o        (rg),
        .cond_o       (cond),
        .running_o    (running),
        .halted_o     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        gcnt  = 8'd0;
        clear_mem();
        #2;
        chk("rst_pc", addr, 0);
        chk("rst_pwm", pwm, 0);
        chk("rst_reg", rg, 0);
        chk("rst_cond", cond, 0);
        chk("rst_run", running, 0);
        chk("rst_halt", halted, 0);
        #10 rst_n = 1'b1;
        tick(1);
        chk("idle_wait_run", running, 0);

        // SET/ARITH wrap then HALT
        mem[0] = 8'h2F; mem[1] = 8'h47; mem[2] = 8'h48; mem[3] = 8'h01;
        en = 1'b1;
        tick(1);
        chk("a_run", running, 1);
        chk("a_pc0", addr, 0);
        tick(1);
        chk("a_set", pwm, 8'h0F);
        tick(1);
        chk("a_add7", pwm, 8'h16);
        tick(1);
        chk("a_sub8", pwm, 8'h0E);
        tick(1);
        chk("a_pwm_end", pwm, 8'h0E);
        chk("a_halted", halted, 1);
        chk("a_pc_halt", addr, 3);
        tick(2);
        chk("a_hold_pc", addr, 3);
        en = 1'b0;
        tick(1);
        chk("a_idle_halt", halted, 0);
        chk("a_idle_pc", addr, 0);
        chk("a_idle_pwm", pwm, 8'h0E);

        // ARITH negative wrap and SHIFT
        clear_mem();
        mem[0] = 8'h22; mem[1] = 8'h4D; mem[2] = 8'h39; mem[3] = 8'h74;
        mem[4] = 8'h7F; mem[5] = 8'h70; mem[6] = 8'h01;
        en = 1'b1;
        tick(2);
        chk("b_set2", pwm, 8'h02);
        tick(1);
        chk("b_sub3_wrap", pwm, 8'hFF);
        tick(1);
        chk("b_setreg", rg, 8'h09);
        tick(1);
        chk("b_shl4", rg, 8'h90);
        tick(1);
        chk("b_shr7", rg, 8'h01);
        tick(1);
        chk("b_shl0", rg, 8'h01);
        chk("b_pc6", addr, 6);
        tick(1);
        chk("b_halted", halted, 1);
        chk("b_pwm_keep", pwm, 8'hFF);

        // HALT -> IDLE -> restart at pc 0, then enable drop mid-run
        en = 1'b0;
        tick(1);
        chk("f_idle_pc", addr, 0);
        chk("f_idle_reg", rg, 8'h01);
        en = 1'b1;
        tick(1);
        chk("f_run", running, 1);
        chk("f_pc0", addr, 0);
        chk("f_no_exec", pwm, 8'hFF);
        tick(1);
        chk("f_exec0", pwm, 8'h02);
        chk("f_pc1", addr, 1);
        en = 1'b0;
        tick(1);
        chk("f_drop_pwm", pwm, 8'h02);
        chk("f_drop_pc", addr, 0);
        chk("f_drop_run", running, 0);

        // CMP/BRANCH/JUMP loop
        clear_mem();
        mem[0] = 8'h24; mem[1] = 8'hC0; mem[2] = 8'hFF; mem[3] = 8'h41; mem[4] = 8'hBD;
        gcnt = 8'd2;
        en = 1'b1;
        tick(3);
        chk("c_cond1", cond, 1);
        chk("c_pc2", addr, 2);
        tick(1);
        chk("c_br_pc1", addr, 1);
        tick(2);
        chk("c_loop_pc1", addr, 1);
        chk("c_loop_pwm", pwm, 8'h04);
        gcnt = 8'd5;
        tick(1);
        chk("c_cond0", cond, 0);
        tick(1);
        chk("c_fall_pc3", addr, 3);
        tick(1);
        chk("c_inc_pwm", pwm, 8'h05);
        tick(1);
        chk("c_jump_pc1", addr, 1);
        chk("c_cond_keep", cond, 0);
        en = 1'b0;
        tick(1);

        // PC wrap over NOPs, then JUMP -16 spin at pc 3
        clear_mem();
        en = 1'b1;
        tick(1);
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            chk("d_pc_wrap", addr, i % 16);
        end
        mem[3] = 8'hB0;
        tick(3);
        chk("d_at3", addr, 3);
        tick(2);
        chk("d_spin3", addr, 3);
        en = 1'b0;
        tick(1);

        // Reset asserted between edges while pwm=0x55
        clear_mem();
        mem[0] = 8'h25; mem[1] = 8'h64; mem[2] = 8'h45; mem[3] = 8'hA0;
        en = 1'b1;
        tick(5);
        chk("e_pwm55", pwm, 8'h55);
        chk("e_spin_pc", addr, 3);
        #3 rst_n = 1'b0;
        #1;
        chk("e_rst_pwm", pwm, 0);
        chk("e_rst_reg", rg, 0);
        chk("e_rst_pc", addr, 0);
        chk("e_rst_run", running, 0);
        chk("e_rst_cond", cond, 0);
        en = 1'b0;
        #2 rst_n = 1'b1;
        tick(3);
        chk("e_wait_run", running, 0);
        chk("e_wait_pwm", pwm, 0);
        chk("e_wait_pc", addr, 0);
        en = 1'b1;
        tick(1);
        chk("e_restart_run", running, 1);
        tick(1);
        chk("e_restart_pwm", pwm, 8'h05);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
